// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer: combinational lookup, registered
// update with 2-bit direction counters, true-LRU ages, and a one-set-per-cycle flush.
module btb_assoc #(
    parameter int PC_W = 32,
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_valid,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [PC_W-1:0] rd_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush_req,
    output logic            flush_busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef enum logic {S_IDLE, S_FLUSH} fsm_t;

    logic             r_valid  [SETS][WAYS];
    logic [TAG_W-1:0] r_tag    [SETS][WAYS];
    logic [PC_W-1:0]  r_target [SETS][WAYS];
    logic [1:0]       r_state  [SETS][WAYS];
    logic [AGE_W-1:0] r_age    [SETS][WAYS];
    fsm_t             r_fsm;
    logic [IDX_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_rd_idx, w_upd_idx;
    logic [TAG_W-1:0] w_rd_tag, w_upd_tag;
    logic [WAYS-1:0]  w_rd_match, w_upd_match;
    logic             w_rd_any, w_upd_hit, w_inv_any;
    logic [AGE_W-1:0] w_rd_way, w_upd_hit_way, w_inv_way, w_old_way, w_upd_way;
    logic [AGE_W-1:0] w_rd_age_new  [WAYS];
    logic [AGE_W-1:0] w_upd_age_new [WAYS];
    logic             w_upd_accept, w_upd_write, w_rd_touch;
    logic             w_unused;

    assign w_rd_idx   = rd_pc[IDX_W+1:2];
    assign w_rd_tag   = rd_pc[PC_W-1:IDX_W+2];
    assign w_upd_idx  = upd_pc[IDX_W+1:2];
    assign w_upd_tag  = upd_pc[PC_W-1:IDX_W+2];
    assign w_unused   = ^{rd_pc[1:0], upd_pc[1:0]};
    assign flush_busy = (r_fsm == S_FLUSH);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_match
            assign w_rd_match[gi]  = r_valid[w_rd_idx][gi]  && (r_tag[w_rd_idx][gi]  == w_rd_tag);
            assign w_upd_match[gi] = r_valid[w_upd_idx][gi] && (r_tag[w_upd_idx][gi] == w_upd_tag);
        end
    endgenerate

    // Descending scans so the lowest matching / invalid way wins.
    always_comb begin
        w_rd_any      = 1'b0;
        w_rd_way      = '0;
        w_upd_hit     = 1'b0;
        w_upd_hit_way = '0;
        w_inv_any     = 1'b0;
        w_inv_way     = '0;
        w_old_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rd_match[w]) begin
                w_rd_any = 1'b1;
                w_rd_way = AGE_W'(w);
            end
            if (w_upd_match[w]) begin
                w_upd_hit     = 1'b1;
                w_upd_hit_way = AGE_W'(w);
            end
            if (!r_valid[w_upd_idx][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = AGE_W'(w);
            end
            if (r_age[w_upd_idx][w] == AGE_W'(WAYS - 1))
                w_old_way = AGE_W'(w);
        end
        w_upd_way = w_upd_hit ? w_upd_hit_way : (w_inv_any ? w_inv_way : w_old_way);
    end

    assign rd_hit    = w_rd_any && !flush_busy;
    assign rd_taken  = rd_hit && r_state[w_rd_idx][w_rd_way][1];
    assign rd_target = rd_hit ? r_target[w_rd_idx][w_rd_way] : '0;

    assign w_upd_accept = upd_valid && !flush_busy;
    assign w_upd_write  = w_upd_accept && (w_upd_hit || upd_taken);
    assign w_rd_touch   = rd_valid && rd_hit && !(w_upd_write && (w_upd_idx == w_rd_idx));

    // LRU touch: ways younger than the touched one age by one, touched way becomes 0.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_rd_age_new[w]  = r_age[w_rd_idx][w];
            w_upd_age_new[w] = r_age[w_upd_idx][w];
            if (AGE_W'(w) == w_rd_way)
                w_rd_age_new[w] = '0;
            else if (r_age[w_rd_idx][w] < r_age[w_rd_idx][w_rd_way])
                w_rd_age_new[w] = r_age[w_rd_idx][w] + AGE_W'(1);
            if (AGE_W'(w) == w_upd_way)
                w_upd_age_new[w] = '0;
            else if (r_age[w_upd_idx][w] < r_age[w_upd_idx][w_upd_way])
                w_upd_age_new[w] = r_age[w_upd_idx][w] + AGE_W'(1);
        end
    end

    function automatic logic [1:0] f_next_state(input logic [1:0] s, input logic t);
        case (s)
            2'b00:   f_next_state = t ? 2'b01 : 2'b00;
            2'b01:   f_next_state = t ? 2'b11 : 2'b00;
            2'b11:   f_next_state = t ? 2'b10 : 2'b01;
            default: f_next_state = t ? 2'b10 : 2'b11;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_state[s][w]  <= 2'b00;
                    r_age[s][w]    <= AGE_W'(w);
                end
            end
            r_fsm <= S_IDLE;
            r_cnt <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_rd_touch) begin
                        for (int w = 0; w < WAYS; w++)
                            r_age[w_rd_idx][w] <= w_rd_age_new[w];
                    end
                    if (w_upd_write) begin
                        for (int w = 0; w < WAYS; w++)
                            r_age[w_upd_idx][w] <= w_upd_age_new[w];
                        r_valid[w_upd_idx][w_upd_way] <= 1'b1;
                        r_tag[w_upd_idx][w_upd_way]   <= w_upd_tag;
                        if (upd_taken)
                            r_target[w_upd_idx][w_upd_way] <= upd_target;
                        r_state[w_upd_idx][w_upd_way] <= w_upd_hit ?
                            f_next_state(r_state[w_upd_idx][w_upd_way], upd_taken) : 2'b11;
                    end
                    if (flush_req) begin
                        r_fsm <= S_FLUSH;
                        r_cnt <= '0;
                    end
                end
                default: begin
                    for (int w = 0; w < WAYS; w++) begin
                        r_valid[r_cnt][w] <= 1'b0;
                        r_state[r_cnt][w] <= 2'b00;
                        r_age[r_cnt][w]   <= AGE_W'(w);
                    end
                    if (r_cnt == IDX_W'(SETS - 1))
                        r_fsm <= S_IDLE;
                    else
                        r_cnt <= r_cnt + IDX_W'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=8, WAYS=2): hand-computed expectations for
// lookup, counter transitions, LRU victim choice, flush and mid-flush reset.
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic        rd_hit;
    logic        rd_taken;
    logic [31:0] rd_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_req;
    logic        flush_busy;

    int checks = 0;
    int failures = 0;

    btb_assoc #(.PC_W(32), .SETS(8), .WAYS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_hit(rd_hit), .rd_taken(rd_taken), .rd_target(rd_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] etg);
        rd_pc = pc;
        #1;
        $display("lookup %s pc=%h hit=%0b taken=%0b target=%h", name, pc, rd_hit, rd_taken, rd_target);
        chk({name, ".hit"}, {31'd0, rd_hit}, {31'd0, eh});
        chk({name, ".taken"}, {31'd0, rd_taken}, {31'd0, et});
        chk({name, ".target"}, rd_target, etg);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        $display("update pc=%h taken=%0b target=%h", pc, t, tg);
    endtask

    initial begin
        rst_n = 1'b0; rd_valid = 1'b0; rd_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 32'h40, 1'b0, 1'b0, 32'h0);
        chk("reset.busy", {31'd0, flush_busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Allocation and 2-bit counter walk on 0x40 (set 0, way 0)
        upd(32'h40, 1'b1, 32'h100);  look("alloc",  32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);    look("nt1",    32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'h0);    look("nt2",    32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b1, 32'h100);  look("t1",     32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b1, 32'h100);  look("t2",     32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h104);  look("t3",     32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1'b1, 32'h104);  look("tsat",   32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1'b0, 32'h0);    look("nt3",    32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1'b0, 32'h0);    look("nt4",    32'h40, 1'b1, 1'b0, 32'h104);

        // LRU: lookup touch of 0x40 makes 0x240 the victim for 0x440
        upd(32'h240, 1'b1, 32'h200);
        rd_valid = 1'b1;
        look("touch", 32'h40, 1'b1, 1'b0, 32'h104);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        upd(32'h440, 1'b1, 32'h300);
        look("evict240", 32'h240, 1'b0, 1'b0, 32'h0);
        look("keep40",   32'h40,  1'b1, 1'b0, 32'h104);
        look("new440",   32'h440, 1'b1, 1'b1, 32'h300);

        // Same-cycle lookup hit on 0x440 and allocate 0x640: only update touch applies
        rd_valid = 1'b1;
        look("same", 32'h440, 1'b1, 1'b1, 32'h300);
        upd(32'h640, 1'b1, 32'h400);
        rd_valid = 1'b0;
        look("same.ev40", 32'h40,  1'b0, 1'b0, 32'h0);
        look("same.440",  32'h440, 1'b1, 1'b1, 32'h300);
        look("same.640",  32'h640, 1'b1, 1'b1, 32'h400);
        upd(32'h840, 1'b1, 32'h500);
        look("lru.ev440", 32'h440, 1'b0, 1'b0, 32'h0);
        look("lru.640",   32'h640, 1'b1, 1'b1, 32'h400);
        look("lru.840",   32'h840, 1'b1, 1'b1, 32'h500);
        upd(32'hA40, 1'b0, 32'h0);
        look("ntmiss.a40", 32'hA40, 1'b0, 1'b0, 32'h0);
        look("ntmiss.640", 32'h640, 1'b1, 1'b1, 32'h400);

        // Fill more sets, then flush with a coincident update
        upd(32'h44, 1'b1, 32'h600);
        upd(32'h48, 1'b1, 32'h700);
        upd(32'h5C, 1'b1, 32'h800);
        look("fill.5c", 32'h5C, 1'b1, 1'b1, 32'h800);
        flush_req = 1'b1;
        chk("flush.pre_busy", {31'd0, flush_busy}, 32'd0);
        upd(32'h4C, 1'b1, 32'h900);
        flush_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("flush.busy%0d", i), {31'd0, flush_busy}, 32'd1);
            look($sformatf("flush.look%0d", i), 32'h640, 1'b0, 1'b0, 32'h0);
            if (i == 2) flush_req = 1'b1;
            if (i == 3) begin
                upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'hA00;
            end
            @(posedge clk); #1;
            flush_req = 1'b0;
            upd_valid = 1'b0;
        end
        chk("flush.done", {31'd0, flush_busy}, 32'd0);
        look("post.640", 32'h640, 1'b0, 1'b0, 32'h0);
        look("post.840", 32'h840, 1'b0, 1'b0, 32'h0);
        look("post.44",  32'h44,  1'b0, 1'b0, 32'h0);
        look("post.5c",  32'h5C,  1'b0, 1'b0, 32'h0);
        look("post.4c",  32'h4C,  1'b0, 1'b0, 32'h0);
        look("post.40",  32'h40,  1'b0, 1'b0, 32'h0);

        // Reset asserted during the fourth busy cycle of a flush
        upd(32'h44, 1'b1, 32'h610);
        look("pre.44", 32'h44, 1'b1, 1'b1, 32'h610);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstflush.busy_before", {31'd0, flush_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstflush.busy", {31'd0, flush_busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        look("rst.44", 32'h44, 1'b0, 1'b0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst.idle", {31'd0, flush_busy}, 32'd0);
        upd(32'h44, 1'b1, 32'h12);
        look("rst.realloc", 32'h44, 1'b1, 1'b1, 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer with 2-bit dynamic predictors and true-LRU replacement.
- IF stage gets a combinational lookup (hit, predicted direction, target) for the fetch PC.
- EX stage writes resolved branches back through a registered update port.
- A multi-cycle flush engine invalidates the whole array, one set per cycle.

Parameters:
- PC_W, 32: PC/target width.
- SETS, 8: number of sets; power of two ≥2. IDX_W = log2(SETS).
- WAYS, 2: ways per set; power of two ≥2. AGE_W = log2(WAYS).
- TAG_W, derived: PC_W - IDX_W - 2. Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid  in  1  IF lookup is real; allowed to touch LRU
- rd_pc  in  PC_W  fetch PC
- rd_hit  out  1  valid tag match in the indexed set
- rd_taken  out  1  predicted taken (state[1] of the hit entry)
- rd_target  out  PC_W  target of the hit entry; 0 on miss
- upd_valid  in  1  resolved control-transfer instruction from EX
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual target
- flush_req  in  1  start full invalidation
- flush_busy  out  1  flush in progress

Behaviour:
- Entry fields: valid, tag[TAG_W], target[PC_W], state[1:0], age[AGE_W].
- State encoding: 00 strong-NT, 01 weak-NT, 10 strong-T, 11 weak-T.
- Reset, asynchronous: all valid=0; state=00; target=0; age of way w = w; FSM=IDLE; flush_busy=0. Outputs therefore rd_hit=0, rd_taken=0, rd_target=0.
- Lookup (combinational, 0 latency):
  - Compare the tag against all ways of set rd_pc index.
  - Hit = valid && tag equal. If several ways match (illegal), the lowest way wins.
  - Miss: rd_taken=0, rd_target=0.
  - While flush_busy, rd_hit, rd_taken and rd_target are forced to 0.
- Update (clk edge, upd_valid=1, not flush_busy):
  - Hit way h:
    - Taken transitions: 00→01→11→10, saturating at 10.
    - Not-taken transitions: 10→11→01→00, saturating at 00.
    - If upd_taken, target←upd_target.
    - Touch h.
  - Miss and upd_taken: allocate victim v.
    - v = lowest-index invalid way, else the way with age==WAYS-1.
    - Write valid=1, tag, target=upd_target, state=11 (weak-T).
    - Touch v.
  - Miss and not taken: no change.
- Touch(w), in set s: every way with age < age[w] increments; age[w]←0. Ages stay a permutation of 0..WAYS-1 at all times.
- Lookup LRU touch: at the edge where rd_valid && rd_hit, touch the hit way.
  - If an update is accepted to the same set in the same cycle, only the update's touch applies.
  - Different sets: both touches apply.
- No read bypass: an update becomes visible to lookups on the cycle after its edge.
- Flush FSM, states IDLE and FLUSH:
  - IDLE, flush_req=1: go to FLUSH with cnt=0; flush_busy=1 from the next cycle.
  - FLUSH, each cycle: set[cnt] gets all valid=0, ages reset to way index, state=00.
  - cnt==SETS-1: return to IDLE; flush_busy=0 the following cycle. Duration is exactly SETS cycles.
  - flush_req while busy is ignored, with no restart.
  - upd_valid during FLUSH is dropped.
  - upd_valid in the same cycle as a flush_req accepted from IDLE is applied, then cleared by the flush.
- rst_n low mid-flush: immediate reset state; the flush is abandoned.

Test Plan:
- Reset, then lookup pc=0x0000_0040 → rd_hit=0, rd_taken=0, rd_target=0; flush_busy=0.
- Update pc=0x40 taken, target 0x100 → next cycle lookup 0x40 gives hit=1, taken=1, target=0x100.
  - Then two not-taken updates → state 11→01→00; rd_taken=0, still hit.
- SETS=8, WAYS=2: allocate taken branches at 0x40, then 0x240 (same index 0). Lookup 0x40 with rd_valid. Allocate 0x440.
  - Required: 0x240 evicted; 0x40 and 0x440 hit.
- Same cycle: rd_valid hit on 0x40 and update miss-allocate to set 0.
  - Required: victim is chosen from ages before the edge; only the update's touch is applied.
- Fill several sets, pulse flush_req.
  - flush_busy high for exactly 8 cycles; lookups miss throughout; an update during the flush is dropped.
  - All lookups miss after the flush; a second flush_req mid-flush does not extend it.
- Assert rst_n low during cycle 3 of a flush → flush_busy=0 immediately; all entries invalid after release.
